// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: state/rule encodings and constants shared by the hazard controller
package hazard_ctrl_pkg;
   localparam int HZ_REG_W = 3;
   localparam logic [15:0] HZ_NOP = 16'h0800;
   typedef enum logic [1:0] {HZ_RUN, HZ_IWAIT, HZ_DWAIT, HZ_HALT} hz_state_e;
   typedef enum logic [3:0] {
      R_HALTED, R_DMEM, R_IHOLD, R_REDIR, R_PEND, R_LU, R_IMEM, R_HALTI, R_NORM
   } hz_rule_e;
endpackage

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: load-use comparator of D-stage sources against the X-stage load destination
module hazard_lu_detect
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_W = HZ_REG_W
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_mem_rd,
   input  logic [REG_W-1:0] ex_rd,
   output logic             lu
);
   assign lu = ex_mem_rd && ex_rd != '0 &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: IF/D stall/flush, D/X bubble and PC-write sequencing; perf counters with HAZ_PERF_CNT_EN
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
`ifdef HAZ_PERF_CNT_EN
   parameter int CNT_W = 16,
`endif
   parameter int REG_W = HZ_REG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_mem_rd,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_redirect,
   input  logic             id_halt,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   output logic             fd_stall,
   output logic             fd_flush,
   output logic             dx_bubble,
   output logic             pc_we,
   output logic             pipe_freeze,
   output logic             halted
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);
   hz_state_e state_q, state_d;
   hz_rule_e  rule;
   logic      flush_pend_q, flush_pend_d;
   logic      lu;
   hazard_lu_detect #(.REG_W(REG_W)) u_lu (
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_use_rs (id_use_rs),
      .id_use_rt (id_use_rt),
      .ex_mem_rd (ex_mem_rd),
      .ex_rd     (ex_rd),
      .lu        (lu)
   );
   // Winning rule this cycle; a wait state whose busy has dropped behaves exactly like RUN
   always_comb
      rule = state_q == HZ_HALT                ? R_HALTED :
             dmem_busy                         ? R_DMEM   :
             state_q == HZ_IWAIT && imem_busy  ? R_IHOLD  :
             ex_redirect                       ? R_REDIR  :
             flush_pend_q                      ? R_PEND   :
             lu                                ? R_LU     :
             imem_busy                         ? R_IMEM   :
             id_halt                           ? R_HALTI  : R_NORM;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= HZ_RUN;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
      end
   always_comb begin
      state_d      = rule inside {R_HALTED, R_HALTI} ? HZ_HALT  :
                     rule == R_DMEM                  ? HZ_DWAIT :
                     rule inside {R_IHOLD, R_IMEM}   ? HZ_IWAIT : HZ_RUN;
      flush_pend_d = rule inside {R_DMEM, R_IHOLD} ? flush_pend_q | ex_redirect : 1'b0;
   end
   always_comb begin
      fd_stall    = rst_n && rule inside {R_DMEM, R_LU, R_HALTI, R_HALTED};
      fd_flush    = !rst_n || rule inside {R_IHOLD, R_REDIR, R_PEND, R_IMEM};
      dx_bubble   = !rst_n || rule inside {R_REDIR, R_LU};
      pc_we       = rst_n && rule inside {R_REDIR, R_PEND, R_NORM};
      pipe_freeze = rst_n && rule == R_DMEM;
      halted      = rst_n && rule == R_HALTED;
   end
`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   always_comb begin
      stall_cnt_d = fd_stall && !halted && stall_cnt_q != '1 ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = fd_flush && flush_cnt_q != '1 ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checking of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
   localparam int CW = 3;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic       id_use_rs = 0, id_use_rt = 0, ex_mem_rd = 0, ex_redirect = 0;
   logic       id_halt = 0, imem_busy = 0, dmem_busy = 0;
   logic       fd_stall, fd_flush, dx_bubble, pc_we, pipe_freeze, halted;
   int         errors = 0, checks = 0;
   bit         m_halt, m_iwait, m_pend;
`ifdef HAZ_PERF_CNT_EN
   logic [CW-1:0] stall_cnt, flush_cnt;
   int            mc_stall, mc_flush;
   hazard_ctrl #(.CNT_W(CW), .REG_W(3)) dut (
`else
   hazard_ctrl #(.REG_W(3)) dut (
`endif
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd),
      .ex_redirect(ex_redirect), .id_halt(id_halt), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
      .fd_stall(fd_stall), .fd_flush(fd_flush), .dx_bubble(dx_bubble), .pc_we(pc_we),
      .pipe_freeze(pipe_freeze), .halted(halted)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );
   always #5 clk = ~clk;
   wire [5:0] outv = {fd_stall, fd_flush, dx_bubble, pc_we, pipe_freeze, halted};
   // Expected {fd_stall, fd_flush, dx_bubble, pc_we, pipe_freeze, halted} from the priority rules
   function automatic logic [5:0] exp_out();
      logic lu_m;
      lu_m = ex_mem_rd && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      if (!rst_n) return 6'b011000;
      if (m_halt) return 6'b100001;
      if (dmem_busy) return 6'b100010;
      if (m_iwait && imem_busy) return 6'b010000;
      if (ex_redirect) return 6'b011100;
      if (m_pend) return 6'b010100;
      if (lu_m) return 6'b101000;
      if (imem_busy) return 6'b010000;
      if (id_halt) return 6'b100000;
      return 6'b000100;
   endfunction
   always @(posedge clk or negedge rst_n) begin
      logic [5:0] e;
      if (!rst_n) begin
         m_halt = 0; m_iwait = 0; m_pend = 0;
`ifdef HAZ_PERF_CNT_EN
         mc_stall = 0; mc_flush = 0;
`endif
      end else begin
         e = exp_out();
`ifdef HAZ_PERF_CNT_EN
         if (e[5] && !e[0]) mc_stall = mc_stall == 2**CW - 1 ? mc_stall : mc_stall + 1;
         if (e[4]) mc_flush = mc_flush == 2**CW - 1 ? mc_flush : mc_flush + 1;
`endif
         if (!m_halt) begin
            if (dmem_busy) begin
               m_pend = m_pend | ex_redirect;
               m_iwait = 0;
            end else if (!(m_iwait && imem_busy)) begin
               m_iwait = e == 6'b010000 && !m_pend;
               m_halt = e == 6'b100000;
               m_pend = 0;
            end else
               m_pend = m_pend | ex_redirect;
         end
      end
   end
   always @(negedge clk) begin
      checks++;
      if (outv !== exp_out()) begin
         errors++;
         $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, outv, exp_out());
      end
`ifdef HAZ_PERF_CNT_EN
      checks++;
      if (stall_cnt !== CW'(mc_stall) || flush_cnt !== CW'(mc_flush)) begin
         errors++;
         $display("FAIL counters t=%0t got=%0d/%0d expected=%0d/%0d", $time, stall_cnt, flush_cnt, mc_stall, mc_flush);
      end
`endif
   end
   task automatic lit(input string n, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", n, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      {id_rs, id_rt, ex_rd} = '0;
      {id_use_rs, id_use_rt, ex_mem_rd, ex_redirect, id_halt, imem_busy, dmem_busy} = '0;
   endtask
   task automatic set_lu();
      ex_mem_rd = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
   endtask
   initial begin
      #2 lit("reset", outv, 6'b011000);
      tick();
      rst_n = 1;
      #2 lit("run_idle", outv, 6'b000100);
`ifdef HAZ_PERF_CNT_EN
      for (int i = 0; i < 5; i++) begin
         tick(); set_lu();
         tick(); idle();
      end
      for (int i = 0; i < 2; i++) begin
         tick(); ex_redirect = 1;
         tick(); idle();
      end
      tick();
      lit("stall_cnt5", stall_cnt, 5);
      lit("flush_cnt2", flush_cnt, 2);
`endif
      tick(); set_lu();
      #2 lit("lu", outv, 6'b101000);
      tick(); idle();
      #2 lit("lu_after", outv, 6'b000100);
      tick(); ex_mem_rd = 1; id_use_rs = 1;
      #2 lit("lu_r0", outv, 6'b000100);
      tick(); idle(); ex_mem_rd = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
      #2 lit("lu_rt", outv, 6'b101000);
      id_use_rt = 0;
      #1 lit("lu_rt_unused", outv, 6'b000100);
      tick(); idle(); ex_redirect = 1;
      #2 lit("redirect", outv, 6'b011100);
      tick(); idle(); imem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #2 lit("fetch_wait", outv, 6'b010000);
         tick();
      end
      imem_busy = 0;
      #2 lit("fetch_done", outv, 6'b000100);
      tick(); dmem_busy = 1; ex_redirect = 1;
      #2 lit("dwait_redir", outv, 6'b100010);
      tick(); ex_redirect = 0;
      #2 lit("dwait_hold", outv, 6'b100010);
      tick(); dmem_busy = 0;
      #2 lit("pend_flush", outv, 6'b010100);
      tick();
      #2 lit("pend_clear", outv, 6'b000100);
      imem_busy = 1; tick(); ex_redirect = 1;
      #2 lit("iwait_redir", outv, 6'b010000);
      tick(); idle();
      #2 lit("iwait_pend", outv, 6'b010100);
      tick(); dmem_busy = 1; imem_busy = 1;
      #2 lit("both_busy", outv, 6'b100010);
      tick(); dmem_busy = 0;
      #2 lit("dmem_then_imem", outv, 6'b010000);
      tick(); idle(); id_halt = 1;
      #2 lit("halt_enter", outv, 6'b100000);
      tick(); idle(); ex_redirect = 1; imem_busy = 1;
      #2 lit("halted", outv, 6'b100001);
      tick(); tick();
      #2 lit("halted_hold", outv, 6'b100001);
      rst_n = 0;
      #1 lit("halt_reset", outv, 6'b011000);
      tick(); idle(); rst_n = 1;
      #2 lit("after_reset", outv, 6'b000100);
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst_n = $urandom_range(0, 39) != 0;
         id_rs = 3'($urandom_range(0, 3));
         id_rt = 3'($urandom_range(0, 3));
         ex_rd = 3'($urandom_range(0, 3));
         id_use_rs = 1'($urandom_range(0, 1));
         id_use_rt = 1'($urandom_range(0, 1));
         ex_mem_rd = $urandom_range(0, 2) == 0;
         ex_redirect = $urandom_range(0, 5) == 0;
         id_halt = $urandom_range(0, 59) == 0;
         imem_busy = $urandom_range(0, 3) == 0;
         dmem_busy = $urandom_range(0, 4) == 0;
      end
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
